// File: rtl/ad_oversampler.sv
// Serial ADC front end: frames nCS, captures DATA_BITS of each frame and
// averages 2^AVG_LOG2 consecutive samples into a level output.
module ad_oversampler #(
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned LEAD_BITS    = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned QUIET_CYCLES = 2,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 SDATA,
  output logic                 nCS,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sampleValid,
  output logic [DATA_BITS-1:0] level,
  output logic                 levelValid,
  output logic                 busy
);

  localparam int unsigned BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ACC_W   = DATA_BITS + AVG_LOG2;

  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]   CAP_FIRST  = BIT_W'(LEAD_BITS);
  localparam logic [BIT_W-1:0]   CAP_LAST   = BIT_W'(LEAD_BITS + DATA_BITS - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   COUNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] QUIET   = 2'd2;

  logic [1:0]           state, stateD;
  logic [BIT_W-1:0]     bitIndex, bitIndexD;
  logic [QUIET_W-1:0]   quietCnt, quietCntD;
  logic [DATA_BITS-1:0] shiftReg, shiftD;
  logic [DATA_BITS-1:0] sampleD, levelD;
  logic                 sampleValidD, levelValidD;
  logic [ACC_W-1:0]     acc, accD, accSum;
  logic [CNT_W-1:0]     count, countD;
  logic                 captureBit;

  assign captureBit = (bitIndex >= CAP_FIRST) && (bitIndex <= CAP_LAST);
  assign busy       = (state != IDLE);

  always_comb begin
    stateD       = state;
    bitIndexD    = bitIndex;
    quietCntD    = quietCnt;
    shiftD       = shiftReg;
    sampleD      = sample;
    sampleValidD = 1'b0;
    levelD       = level;
    levelValidD  = 1'b0;
    accD         = acc;
    countD       = count;
    accSum       = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          stateD    = CONVERT;
          bitIndexD = '0;
        end
      end
      CONVERT: begin
        if (captureBit) begin
          shiftD = (shiftReg << 1) | DATA_BITS'(SDATA);
        end
        bitIndexD = bitIndex + 1'b1;
        if (bitIndex == LAST_BIT) begin
          stateD       = QUIET;
          quietCntD    = '0;
          sampleD      = shiftD;
          sampleValidD = 1'b1;
          // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
          accSum       = acc + ACC_W'(shiftD);
          if (count == COUNT_LAST) begin
            levelD      = accSum[ACC_W-1 -: DATA_BITS];
            levelValidD = 1'b1;
            accD        = '0;
            countD      = '0;
          end else begin
            accD   = accSum;
            countD = count + 1'b1;
          end
        end
      end
      QUIET: begin
        quietCntD = quietCnt + 1'b1;
        if (quietCnt == QUIET_LAST) begin
          bitIndexD = '0;
          if (enable) begin
            stateD = CONVERT;
          end else begin
            // A partial average never spans an idle gap.
            stateD = IDLE;
            accD   = '0;
            countD = '0;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bitIndex    <= '0;
      quietCnt    <= '0;
      shiftReg    <= '0;
      sample      <= '0;
      sampleValid <= 1'b0;
      level       <= '0;
      levelValid  <= 1'b0;
      acc         <= '0;
      count       <= '0;
      nCS         <= 1'b1;
    end else begin
      state       <= stateD;
      bitIndex    <= bitIndexD;
      quietCnt    <= quietCntD;
      shiftReg    <= shiftD;
      sample      <= sampleD;
      sampleValid <= sampleValidD;
      level       <= levelD;
      levelValid  <= levelValidD;
      acc         <= accD;
      count       <= countD;
      nCS         <= (stateD != CONVERT);
    end
  end

endmodule

// File: tb/tb_ad_oversampler.sv
// Bench for ad_oversampler: an nCS-driven ADC model feeds both a default instance
// and an AVG_LOG2=0 instance; a frame-level reference model predicts every output.
module tb_ad_oversampler;

  localparam int FB = 16;
  localparam int LB = 4;
  localparam int DB = 8;
  localparam int QC = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic SDATA = 1'b0;
  logic nCS, sv, lv, busy;
  logic [7:0] sample, level;
  logic nCS1, sv1, lv1, busy1;
  logic [7:0] sample1, level1;

  always #5 clock = ~clock;

  ad_oversampler dut (
    .clock(clock), .reset(reset), .enable(enable), .SDATA(SDATA), .nCS(nCS),
    .sample(sample), .sampleValid(sv), .level(level), .levelValid(lv), .busy(busy)
  );

  ad_oversampler #(.AVG_LOG2(0)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .SDATA(SDATA), .nCS(nCS1),
    .sample(sample1), .sampleValid(sv1), .level(level1), .levelValid(lv1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] wordQ[$];
  logic [15:0] curWord = '0;
  int lowRun = 0;
  int highRun = 100;
  int nFalls = 0;
  int nSv = 0;
  int nLv = 0;
  int cycle = 0;
  int fallCycle[$];
  int avgQ[$];
  logic [7:0] expSample = '0;
  logic [7:0] expLevel = '0;
  logic expSv, expLv;
  logic resetAtEdge = 1'b0;

  initial forever begin
    @(posedge clock);
    resetAtEdge = reset;
    cycle++;
  end

  // ADC model plus frame-level reference model, evaluated mid-cycle.
  initial forever begin
    @(negedge clock);
    expSv = 1'b0;
    expLv = 1'b0;
    if (resetAtEdge) begin
      checks++;
      if (nCS !== 1'b1 || sv !== 1'b0 || lv !== 1'b0 || sample !== 8'h00 || level !== 8'h00 ||
          busy !== 1'b0 || sample1 !== 8'h00 || level1 !== 8'h00 || sv1 !== 1'b0 || lv1 !== 1'b0)
        begin
        errors++;
        $display("FAIL reset_outputs: nCS=%b sv=%b lv=%b sample=%h level=%h busy=%b, want 1 0 0 00 00 0",
                 nCS, sv, lv, sample, level, busy);
      end
      expSample = '0;
      expLevel  = '0;
      avgQ.delete();
      lowRun  = 0;
      highRun = 100;
    end else if (nCS === 1'b0) begin
      if (lowRun == 0) begin
        nFalls++;
        fallCycle.push_back(cycle);
        checks++;
        if (highRun < QC) begin
          errors++;
          $display("FAIL quiet_gap: got %0d high cycles, want >= %0d", highRun, QC);
        end
        curWord = (wordQ.size() > 0) ? wordQ.pop_front() : 16'($urandom);
      end
      SDATA = curWord[FB-1-lowRun];
      lowRun++;
      highRun = 0;
      checks++;
      if (lowRun > FB || busy !== 1'b1) begin
        errors++;
        $display("FAIL frame_low: lowRun=%0d busy=%b, want <= %0d and 1", lowRun, busy, FB);
      end
    end else begin
      if (lowRun > 0) begin
        checks++;
        if (lowRun != FB) begin
          errors++;
          $display("FAIL frame_len: got %0d low cycles, want %0d", lowRun, FB);
        end
        expSv = 1'b1;
        expSample = curWord[FB-1-LB -: DB];
        avgQ.push_back(int'(expSample));
        if (avgQ.size() == 4) begin
          int sum;
          sum = 0;
          foreach (avgQ[i]) sum += avgQ[i];
          expLevel = 8'(sum / 4);
          expLv = 1'b1;
          avgQ.delete();
        end
      end
      lowRun = 0;
      highRun++;
      if (highRun > QC) avgQ.delete();
      SDATA = 1'($urandom);
    end
    if (!resetAtEdge) begin
      if (sv === 1'b1) nSv++;
      if (lv === 1'b1) nLv++;
      checks++;
      if (sv !== expSv || lv !== expLv) begin
        errors++;
        $display("FAIL valid_pulses: sv=%b lv=%b, want %b %b", sv, lv, expSv, expLv);
      end
      checks++;
      if (sample !== expSample || level !== expLevel) begin
        errors++;
        $display("FAIL sample_level: sample=%h level=%h, want %h %h", sample, level, expSample,
                 expLevel);
      end
      checks++;
      if (sample1 !== expSample || level1 !== expSample || sv1 !== expSv || lv1 !== expSv) begin
        errors++;
        $display("FAIL avg0: sample=%h level=%h sv=%b lv=%b, want %h %h %b %b", sample1, level1,
                 sv1, lv1, expSample, expSample, expSv, expSv);
      end
    end
  end

  function automatic logic [15:0] mkWord(input logic [7:0] d);
    logic [3:0] a, b;
    a = 4'($urandom);
    b = 4'($urandom);
    return {a, d, b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || nCS !== 1'b1) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b nCS=%b after %0d cycles, want 0 1", busy, nCS, n);
    end
  endtask

  // Runs n frames; enable drops dropDelay cycles into the last frame.
  task automatic runFrames(input int n, input int dropDelay);
    int start, budget;
    start  = nFalls;
    budget = 0;
    enable = 1'b1;
    while (nFalls - start < n && budget < 40 * n) begin
      tick();
      budget++;
    end
    checks++;
    if (nFalls - start < n) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames, want %0d", nFalls - start, n);
    end
    repeat (dropDelay) tick();
    enable = 1'b0;
    waitIdle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (nCS !== 1'b1 || busy !== 1'b0 || sample !== 8'h00 || level !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: nCS=%b busy=%b sample=%h level=%h, want 1 0 00 00", nCS, busy,
               sample, level);
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (nCS !== 1'b1 || busy !== 1'b0 || nSv != 0) begin
      errors++;
      $display("FAIL idle_after_reset: nCS=%b busy=%b pulses=%0d, want 1 0 0", nCS, busy, nSv);
    end
  endtask

  task automatic test_single();
    int s0;
    s0 = nSv;
    wordQ.push_back(16'h0A50);
    runFrames(1, 0);
    checks++;
    if (nSv - s0 != 1 || sample !== 8'hA5 || sample1 !== 8'hA5 || level1 !== 8'hA5) begin
      errors++;
      $display("FAIL single_frame: pulses=%0d sample=%h avg0 sample=%h level=%h, want 1 a5 a5 a5",
               nSv - s0, sample, sample1, level1);
    end
    checks++;
    if (level !== 8'h00) begin
      errors++;
      $display("FAIL level_partial: got %h, want 00", level);
    end
  endtask

  task automatic test_average();
    int s0, l0;
    s0 = nSv;
    l0 = nLv;
    for (int i = 0; i < 4; i++) wordQ.push_back(mkWord(8'(8'h10 + i)));
    runFrames(4, 0);
    checks++;
    if (nSv - s0 != 4 || nLv - l0 != 1 || level !== 8'h11) begin
      errors++;
      $display("FAIL average: sv=%0d lv=%0d level=%h, want 4 1 11", nSv - s0, nLv - l0, level);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) wordQ.push_back(mkWord(8'hFF));
    runFrames(4, 0);
    checks++;
    if (level !== 8'hFF) begin
      errors++;
      $display("FAIL full_scale: got %h, want ff", level);
    end
    for (int i = 0; i < 4; i++) wordQ.push_back(mkWord(8'h00));
    runFrames(4, 0);
    checks++;
    if (level !== 8'h00) begin
      errors++;
      $display("FAIL zero_scale: got %h, want 00", level);
    end
  endtask

  task automatic test_period();
    int start, budget;
    start  = nFalls;
    budget = 0;
    fallCycle.delete();
    enable = 1'b1;
    while (nFalls - start < 5 && budget < 200) begin
      tick();
      budget++;
      if (nFalls - start >= 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_continuous: got %b, want 1", busy);
        end
      end
    end
    enable = 1'b0;
    waitIdle();
    checks++;
    if (fallCycle.size() < 5) begin
      errors++;
      $display("FAIL period_count: got %0d falls, want 5", fallCycle.size());
    end
    for (int i = 1; i < fallCycle.size(); i++) begin
      checks++;
      if (fallCycle[i] - fallCycle[i-1] != FB + QC) begin
        errors++;
        $display("FAIL period: got %0d cycles, want %0d", fallCycle[i] - fallCycle[i-1], FB + QC);
      end
    end
  endtask

  task automatic test_drop();
    int s0, l0;
    s0 = nSv;
    l0 = nLv;
    for (int i = 0; i < 3; i++) wordQ.push_back(16'($urandom));
    runFrames(3, 4);
    checks++;
    if (nSv - s0 != 3 || nLv - l0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_enable: sv=%0d lv=%0d busy=%b, want 3 0 0", nSv - s0, nLv - l0, busy);
    end
    l0 = nLv;
    for (int i = 0; i < 4; i++) wordQ.push_back(mkWord(8'h40));
    runFrames(4, 0);
    checks++;
    if (level !== 8'h40 || nLv - l0 != 1) begin
      errors++;
      $display("FAIL restart_average: level=%h lv=%0d, want 40 1", level, nLv - l0);
    end
  endtask

  task automatic test_reset_mid();
    int start, budget, s0;
    start  = nFalls;
    budget = 0;
    enable = 1'b1;
    while (nFalls == start && budget < 50) begin
      tick();
      budget++;
    end
    enable = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (nCS !== 1'b1 || sample !== 8'h00 || level !== 8'h00 || sv !== 1'b0 || lv !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: nCS=%b sample=%h level=%h sv=%b lv=%b busy=%b, want 1 00 00 0 0 0",
               nCS, sample, level, sv, lv, busy);
    end
    reset = 1'b0;
    s0 = nSv;
    repeat (6) tick();
    checks++;
    if (nSv != s0 || nCS !== 1'b1) begin
      errors++;
      $display("FAIL reset_quiet: pulses=%0d nCS=%b, want 0 1", nSv - s0, nCS);
    end
    wordQ.push_back(mkWord(8'h33));
    runFrames(1, 0);
    checks++;
    if (nSv - s0 != 1 || sample !== 8'h33) begin
      errors++;
      $display("FAIL fresh_frame: pulses=%0d sample=%h, want 1 33", nSv - s0, sample);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n, s0;
      n  = int'($urandom_range(1, 6));
      s0 = nSv;
      for (int i = 0; i < n; i++) wordQ.push_back(16'($urandom));
      runFrames(n, int'($urandom_range(0, 10)));
      checks++;
      if (nSv - s0 != n) begin
        errors++;
        $display("FAIL random_frames: got %0d samples, want %0d", nSv - s0, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_saturate();
    test_period();
    test_drop();
    test_random();
    test_reset_mid();
    test_random();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
